// File: rtl/ram_bist.sv
// March-free RAM self-test: writes an address-derived pattern to every location,
// reads everything back through a latency-matched pipeline and reports the result.
module ram_bist #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                         state_q;
    logic [DATA_W-1:0]              seed_q;
    logic [DATA_W-1:0]              memDataIn_q;
    logic [ADDR_W-1:0]              memAddr_q;
    logic                           memEnable_q;
    logic                           memWriteEn_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           pass_q;
    logic [ADDR_W:0]                errCount_q;
    logic [ADDR_W-1:0]              firstErrAddr_q;
    logic [DATA_W-1:0]              firstErrData_q;
    logic [RD_LAT-1:0]              pipeValid_q;
    logic [RD_LAT-1:0][ADDR_W-1:0]  pipeAddr_q;
    logic [RD_LAT-1:0][DATA_W-1:0]  pipeExp_q;

    logic                           isLastAddr;
    logic                           abortNow;
    logic                           mismatch;
    logic [ADDR_W:0]                errCount_d;
    logic [ADDR_W-1:0]              addrNext_d;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] s);
        return (DATA_W'(a) << 1) + s;
    endfunction

    always_comb begin
        isLastAddr = (memAddr_q == LAST_ADDR);
        addrNext_d = memAddr_q + 1'b1;
        abortNow   = abort && (state_q == S_WRITE || state_q == S_READ || state_q == S_DRAIN);
        mismatch   = pipeValid_q[RD_LAT-1] && (mem_data_out != pipeExp_q[RD_LAT-1]);
        errCount_d = (errCount_q == '1) ? errCount_q : errCount_q + 1'b1;
    end

    // The pipeline tail lines up with the edge on which the RAM's read data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            seed_q         <= '0;
            memDataIn_q    <= '0;
            memAddr_q      <= '0;
            memEnable_q    <= 1'b0;
            memWriteEn_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            errCount_q     <= '0;
            firstErrAddr_q <= '0;
            firstErrData_q <= '0;
            pipeValid_q    <= '0;
            pipeAddr_q     <= '0;
            pipeExp_q      <= '0;
        end else begin
            for (int i = 1; i < RD_LAT; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeAddr_q[i]  <= pipeAddr_q[i-1];
                pipeExp_q[i]   <= pipeExp_q[i-1];
            end
            pipeValid_q[0] <= (state_q == S_READ);
            pipeAddr_q[0]  <= memAddr_q;
            pipeExp_q[0]   <= pattern(memAddr_q, seed_q);

            if (mismatch && !abortNow) begin
                errCount_q <= errCount_d;
                if (errCount_q == '0) begin
                    firstErrAddr_q <= pipeAddr_q[RD_LAT-1];
                    firstErrData_q <= mem_data_out;
                end
            end

            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q        <= S_WRITE;
                        seed_q         <= seed;
                        busy_q         <= 1'b1;
                        pass_q         <= 1'b0;
                        errCount_q     <= '0;
                        firstErrAddr_q <= '0;
                        firstErrData_q <= '0;
                        memAddr_q      <= '0;
                        memEnable_q    <= 1'b1;
                        memWriteEn_q   <= 1'b1;
                        memDataIn_q    <= pattern('0, seed);
                    end
                end
                S_WRITE: begin
                    if (isLastAddr) begin
                        state_q      <= S_READ;
                        memAddr_q    <= '0;
                        memWriteEn_q <= 1'b0;
                        memDataIn_q  <= '0;
                    end else begin
                        memAddr_q   <= addrNext_d;
                        memDataIn_q <= pattern(addrNext_d, seed_q);
                    end
                end
                S_READ: begin
                    if (isLastAddr) begin
                        state_q     <= S_DRAIN;
                        memAddr_q   <= '0;
                        memEnable_q <= 1'b0;
                    end else begin
                        memAddr_q <= addrNext_d;
                    end
                end
                S_DRAIN: begin
                    if (pipeValid_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (errCount_q == '0);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Abort drops the RAM off the bus and discards in-flight reads; partial results stay.
            if (abortNow) begin
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
                done_q       <= 1'b0;
                memEnable_q  <= 1'b0;
                memWriteEn_q <= 1'b0;
                memAddr_q    <= '0;
                memDataIn_q  <= '0;
                pipeValid_q  <= '0;
            end
        end
    end

    assign mem_data_in    = memDataIn_q;
    assign mem_addr       = memAddr_q;
    assign mem_enable     = memEnable_q;
    assign mem_write_en   = memWriteEn_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = errCount_q;
    assign first_err_addr = firstErrAddr_q;
    assign first_err_data = firstErrData_q;

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: a behavioural RAM with fault hooks, start-time expectations queued
// to a done-triggered monitor, plus direct checks around reset and abort.
module tb_ram_bist;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] seed;
    logic [15:0] mem_data_in;
    logic [7:0]  mem_addr;
    logic        mem_enable;
    logic        mem_write_en;
    logic [15:0] mem_data_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [8:0]  err_count;
    logic [7:0]  first_err_addr;
    logic [15:0] first_err_data;

    always #5 clk = ~clk;

    ram_bist #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .seed           (seed),
        .mem_data_in    (mem_data_in),
        .mem_addr       (mem_addr),
        .mem_enable     (mem_enable),
        .mem_write_en   (mem_write_en),
        .mem_data_out   (mem_data_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data)
    );

    logic [15:0] memory [256];
    logic [15:0] rdData;
    logic        stuckBit0;
    logic        injectReq;
    logic [7:0]  injectAddr;
    logic [15:0] injectData;

    // Single-port RAM, one-cycle read latency; injection lets the bench corrupt a word.
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_write_en) memory[mem_addr] <= mem_data_in;
            else              rdData <= memory[mem_addr];
        end
        if (injectReq) memory[injectAddr] <= injectData;
    end

    assign mem_data_out = rdData | {15'b0, stuckBit0};

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    typedef struct {
        logic        passExp;
        logic [8:0]  errExp;
        logic [7:0]  addrExp;
        logic [15:0] dataExp;
        int          doneEdge;
    } exp_t;

    exp_t sbQ[$];
    exp_t monE;
    int   errors    = 0;
    int   checks    = 0;
    int   doneCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] s, output int c0);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0    = cycleCnt;
    endtask

    task automatic pushExp(input logic p, input logic [8:0] e, input logic [7:0] a,
                           input logic [15:0] d, input int edgeNum);
        exp_t x;
        x.passExp  = p;
        x.errExp   = e;
        x.addrExp  = a;
        x.dataExp  = d;
        x.doneEdge = edgeNum;
        sbQ.push_back(x);
    endtask

    task automatic waitDone(input int prev);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (doneCount != prev) begin
                repeat (3) @(negedge clk);
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL doneTimeout: actual=no done expected=done within 1000 cycles");
    endtask

    // Monitor: every done pulse is matched against the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                doneCount++;
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedDone: actual=done at %0d expected=no done", cycleCnt);
                end else begin
                    monE = sbQ.pop_front();
                    checkOutput("pass", 32'(pass), 32'(monE.passExp));
                    checkOutput("errCount", 32'(err_count), 32'(monE.errExp));
                    checkOutput("firstErrAddr", 32'(first_err_addr), 32'(monE.addrExp));
                    checkOutput("firstErrData", 32'(first_err_data), 32'(monE.dataExp));
                    checkOutput("doneEdge", 32'(cycleCnt), 32'(monE.doneEdge));
                end
                @(negedge clk);
                checkOutput("doneOnePulse", 32'(done), 32'd0);
                checkOutput("busyAfterDone", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: actual=still running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int c0;
        int prev;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        seed       = '0;
        stuckBit0  = 1'b0;
        injectReq  = 1'b0;
        injectAddr = '0;
        injectData = '0;
        #23;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstPass", 32'(pass), 32'd0);
        checkOutput("rstEnable", 32'(mem_enable), 32'd0);
        checkOutput("rstWriteEn", 32'(mem_write_en), 32'd0);
        checkOutput("rstAddr", 32'(mem_addr), 32'd0);
        checkOutput("rstErrCount", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        prev = doneCount;
        applyStimulus(16'h0000, c0);
        checkOutput("e0Busy", 32'(busy), 32'd1);
        checkOutput("e0WriteEn", 32'(mem_write_en), 32'd1);
        checkOutput("e0DataIn", 32'(mem_data_in), 32'h0000);
        pushExp(1'b1, 9'd0, 8'd0, 16'h0000, c0 + 514);
        waitDone(prev);
        checkOutput("mem1Seed0", 32'(memory[1]), 32'h0002);
        checkOutput("mem255Seed0", 32'(memory[255]), 32'h01FE);

        prev = doneCount;
        applyStimulus(16'hFFF0, c0);
        pushExp(1'b1, 9'd0, 8'd0, 16'h0000, c0 + 514);
        waitDone(prev);
        checkOutput("mem8Wrap", 32'(memory[8]), 32'h0000);
        checkOutput("mem255Wrap", 32'(memory[255]), 32'h01EE);

        prev = doneCount;
        applyStimulus(16'h1234, c0);
        pushExp(1'b0, 9'd1, 8'd37, 16'hDEAD, c0 + 514);
        repeat (260) @(negedge clk);
        injectAddr = 8'd37;
        injectData = 16'hDEAD;
        injectReq  = 1'b1;
        @(posedge clk);
        #1;
        injectReq = 1'b0;
        waitDone(prev);

        prev      = doneCount;
        stuckBit0 = 1'b1;
        applyStimulus(16'h0100, c0);
        pushExp(1'b0, 9'd256, 8'd0, 16'h0101, c0 + 514);
        waitDone(prev);
        stuckBit0 = 1'b0;

        prev = doneCount;
        applyStimulus(16'h0042, c0);
        repeat (356) @(negedge clk);
        checkOutput("preAbortBusy", 32'(busy), 32'd1);
        checkOutput("preAbortEnable", 32'(mem_enable), 32'd1);
        checkOutput("preAbortWriteEn", 32'(mem_write_en), 32'd0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortEnable", 32'(mem_enable), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        checkOutput("abortPass", 32'(pass), 32'd0);
        repeat (300) @(negedge clk);
        checkOutput("noDoneAfterAbort", 32'(doneCount), 32'(prev));
        applyStimulus(16'h0042, c0);
        pushExp(1'b1, 9'd0, 8'd0, 16'h0000, c0 + 514);
        waitDone(prev);

        prev = doneCount;
        applyStimulus(16'h5555, c0);
        repeat (50) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstBusy", 32'(busy), 32'd0);
        checkOutput("asyncRstEnable", 32'(mem_enable), 32'd0);
        checkOutput("asyncRstWriteEn", 32'(mem_write_en), 32'd0);
        checkOutput("asyncRstAddr", 32'(mem_addr), 32'd0);
        checkOutput("asyncRstDataIn", 32'(mem_data_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h5555, c0);
        pushExp(1'b1, 9'd0, 8'd0, 16'h0000, c0 + 514);
        waitDone(prev);
        checkOutput("mem255AfterRst", 32'(memory[255]), 32'h5753);
        checkOutput("queueDrained", 32'(sbQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_bist.md
Name: ram_bist

Overview:
- Built-in self-test initiator that drives the single-port synchronous `ram` block through its `data_in`/`data_out`/`addr`/`enable`/`write_en` interface.
- On `start`, it writes a seeded address-derived pattern to every location, then reads every location back and compares each word against the expected value.
- It reports `pass`/`fail`, the error count and the first failing address and data.
- It sits beside the RAM as its sole master during test.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.
- RD_LAT, 1, RAM read latency in cycles from the read-sampling edge to valid `data_out`; legal range 1..4.
- DEPTH, 2**ADDR_W, number of locations tested (derived; must not be overridden).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin test; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE with no done pulse.
- seed  in  DATA_W  pattern seed; captured when start is accepted.
- mem_data_in  out  DATA_W  to RAM data_in.
- mem_addr  out  ADDR_W  to RAM addr.
- mem_enable  out  1  to RAM enable.
- mem_write_en  out  1  to RAM write_en.
- mem_data_out  in  DATA_W  from RAM data_out.
- busy  out  1  high from the start-accept edge until the done pulse ends.
- done  out  1  one-cycle completion pulse.
- pass  out  1  result; valid while done is high and held until the next accepted start.
- err_count  out  ADDR_W+1  number of mismatches; saturates at all-ones.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- first_err_data  out  DATA_W  data read at the first mismatch.

Behaviour:
- All outputs are registered.
- Reset values: mem_* = 0; busy = 0; done = 0; pass = 0; err_count = 0; first_err_addr = 0; first_err_data = 0; state = IDLE.
- Pattern: expected(a) = ((a zero-extended to DATA_W) << 1) + seed_q, modulo 2^DATA_W.
- State IDLE: mem_enable = 0 and mem_write_en = 0.
  - start = 1 at edge E0 captures seed, clears err_count/first_err_*/pass, sets busy, and moves to WRITE.
  - At E0, drive mem_addr = 0, mem_enable = 1, mem_write_en = 1, mem_data_in = expected(0).
- State WRITE: one write per cycle. The RAM samples address k at edge E(k+1).
  - After address DEPTH-1 is presented, move to READ at edge E(DEPTH).
  - At E(DEPTH), drive mem_addr = 0, mem_write_en = 0, mem_enable = 1.
- State READ: one read issued per cycle over addresses 0..DEPTH-1.
  - Each issued read pushes {valid, addr, expected} into an RD_LAT-deep shift pipeline.
  - After the last issue, move to DRAIN with mem_enable = 0.
- Compare: when a pipeline entry matures (RD_LAT edges after the RAM sampled its read), compare mem_data_out with the expected value on that edge.
  - On mismatch, increment err_count with saturation.
  - If this is the first mismatch, latch addr into first_err_addr and mem_data_out into first_err_data.
- State DRAIN: wait until the pipeline is empty, then move to DONE.
- State DONE: done = 1 for exactly one cycle; pass = (err_count == 0); then busy = 0 and return to IDLE.
- Timing: done is high in the cycle after edge E(2*DEPTH+RD_LAT+1), where E0 is the start-accept edge. A test with DEPTH = 256 and RD_LAT = 1 therefore takes 514 edges.
- Address wrap: the address counter is ADDR_W bits. Reaching DEPTH-1 ends the phase; the wrap to 0 is not treated as another location.
- Ignored inputs: start while busy, and start coincident with the done cycle, are ignored.
- abort while busy: next edge goes to IDLE with mem_enable = 0, busy = 0, done not pulsed, and the pipeline cleared. Results keep their partial values; pass stays 0.
- abort in IDLE: no effect. abort and start together in IDLE: start wins.
- Reset mid-test: immediate return to reset values. The RAM contents are not restored.

Test Plan:
- Reset, seed = 0, start pulse, RAM model with RD_LAT = 1 -> writes 0,2,4,…,510 to addr 0..255; reads back; done at E0+514; pass = 1; err_count = 0.
- seed = 16'hFFF0 -> addr 8 written as 16'h0000 (wrap); pass = 1.
- Bench overwrites rd.memory[37] = 16'hDEAD after WRITE ends and before the addr-37 read -> err_count = 1, first_err_addr = 37, first_err_data = 16'hDEAD, pass = 0.
- Stuck-at-1 bit 0 on all RAM reads -> err_count = 256, first_err_addr = 0, first_err_data = seed|1; no overflow past 511.
- abort asserted at the 100th READ cycle -> next cycle busy = 0, mem_enable = 0, no done; a new start then completes with pass = 1.
- rst_n dropped asynchronously mid-WRITE -> all outputs go to 0 immediately, without waiting for a clock edge; a start issued after release runs a full, correct test.
